// File: rtl/ex_mem_pipe_pkg.sv
// Shared constants and encodings for the EX->MEM stage register.
// The payload reset values below are what MEM sees for an empty stage.
package ex_mem_pipe_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int RADDR_W_DEF = 5;
  localparam int MEMOP_W_DEF = 4;
  localparam int CNT_W_DEF   = 16;

  localparam logic RST_ENABLE    = 1'b1;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam int   NOP_REG_ADDR  = 0;
  localparam int   ZERO_WORD     = 0;

  typedef enum logic [3:0] {
    MEMOP_NONE = 4'h0,
    MEMOP_LB   = 4'h1,
    MEMOP_LH   = 4'h2,
    MEMOP_LW   = 4'h3,
    MEMOP_SB   = 4'h4,
    MEMOP_SH   = 4'h5,
    MEMOP_SW   = 4'h6
  } memop_e;

  localparam int MEMOP_NONE_VAL = 0;

endpackage

// File: rtl/ex_mem_pipe_if.sv
// One pipeline link: valid/ready handshake plus the write-back and memory fields.
// The producer uses master, the consumer uses slave.
interface ex_mem_pipe_if
  import ex_mem_pipe_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int MEMOP_W = MEMOP_W_DEF
);
  logic               valid;
  logic               ready;
  logic [RADDR_W-1:0] wreg_addr;
  logic               wreg_enable;
  logic [DATA_W-1:0]  wdata;
  logic [MEMOP_W-1:0] memop;
  logic [DATA_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  sdata;

  modport master (
    output valid, wreg_addr, wreg_enable, wdata, memop, mem_addr, sdata,
    input  ready
  );

  modport slave (
    input  valid, wreg_addr, wreg_enable, wdata, memop, mem_addr, sdata,
    output ready
  );
endinterface

// File: rtl/pipe_skid_buf.sv
// Generic two-entry valid/ready buffer: a main output register plus a skid entry,
// so upstream ready comes straight from a flop. Flush empties both entries.
module pipe_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             accept, advance;

  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign accept    = in_valid & ~skid_valid_q;
  assign advance   = ~main_valid_q | out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (advance) begin
      // Skid holds the older op, so it drains before anything new is taken.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) main_data_d = in_data;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/ex_mem_pipe.sv
// EX->MEM stage register: skid-buffered handshake, NOP forcing of empty slots,
// ALU-result forwarding toward ID/EX and a saturating MEM stall counter.
module ex_mem_pipe
  import ex_mem_pipe_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int MEMOP_W = MEMOP_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  ex_mem_pipe_if.slave       ex,
  ex_mem_pipe_if.master      mem,
  output logic               fwd_enable,
  output logic [RADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0]  fwd_data,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam int PW = RADDR_W + 1 + DATA_W + MEMOP_W + 2 * DATA_W;

  logic [PW-1:0]      in_pl, out_pl;
  logic               out_valid;
  logic [RADDR_W-1:0] o_wreg_addr;
  logic               o_wreg_enable;
  logic [DATA_W-1:0]  o_wdata, o_mem_addr, o_sdata;
  logic [MEMOP_W-1:0] o_memop;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  assign in_pl = {ex.wreg_addr, ex.wreg_enable, ex.wdata, ex.memop, ex.mem_addr, ex.sdata};

  pipe_skid_buf #(.WIDTH(PW)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (ex.valid),
    .in_ready  (ex.ready),
    .in_data   (in_pl),
    .out_valid (out_valid),
    .out_ready (mem.ready),
    .out_data  (out_pl)
  );

  assign {o_wreg_addr, o_wreg_enable, o_wdata, o_memop, o_mem_addr, o_sdata} = out_pl;

  // An empty slot must look like a NOP to MEM, whatever stale data the flops hold.
  always_comb begin
    mem.valid       = out_valid;
    mem.wreg_addr   = RADDR_W'(NOP_REG_ADDR);
    mem.wreg_enable = WRITE_DISABLE;
    mem.wdata       = DATA_W'(ZERO_WORD);
    mem.memop       = MEMOP_W'(MEMOP_NONE_VAL);
    mem.mem_addr    = DATA_W'(ZERO_WORD);
    mem.sdata       = DATA_W'(ZERO_WORD);
    if (out_valid) begin
      mem.wreg_addr   = o_wreg_addr;
      mem.wreg_enable = o_wreg_enable;
      mem.wdata       = o_wdata;
      mem.memop       = o_memop;
      mem.mem_addr    = o_mem_addr;
      mem.sdata       = o_sdata;
    end
  end

  // Loads produce their value only in MEM, so only pure ALU results are forwarded.
  assign fwd_enable = out_valid & o_wreg_enable & (o_memop == MEMOP_W'(MEMOP_NONE_VAL));
  assign fwd_addr   = mem.wreg_addr;
  assign fwd_data   = mem.wdata;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !mem.ready && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule
